// File: rtl/mux_n_1_hs.sv
// N-to-1 registered multiplexer with per-channel valid/ready handshake.
// Selection is either by external index (MODE=0) or round-robin over valid channels (MODE=1).
module mux_n_1_hs #(
   parameter int DW   = 4,
   parameter int N    = 4,
   parameter int MODE = 0,
   localparam int SW  = $clog2(N)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [N*DW-1:0] i_data,
   input  logic [N-1:0]    i_valid,
   output logic [N-1:0]    o_ready,
   input  logic [SW-1:0]   i_sel,
   output logic [DW-1:0]   o_data,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [SW-1:0]   o_grant,
   output logic [SW-1:0]   o_rr_ptr
);

   // Handshake: a beat moves from channel k when o_ready[k] && i_valid[k] at a
   // rising edge; the output beat moves when o_valid && i_ready. o_ready depends
   // combinationally on i_ready (no skid buffer), never on i_valid in MODE=0.
   logic          load_en;
   logic          cand_ok;
   logic [SW-1:0] cand;
   logic          take;
   logic [SW-1:0] rr_ptr;

   assign load_en  = !o_valid || i_ready;
   assign o_rr_ptr = rr_ptr;

   always_comb begin
      cand    = '0;
      cand_ok = 1'b0;
      if (MODE == 0) begin
         cand    = i_sel;
         cand_ok = (int'(i_sel) < N);
      end else begin
         // Scan starting at the pointer so the last winner gets lowest priority.
         for (int i = 0; i < N; i++) begin
            if (!cand_ok && i_valid[(int'(rr_ptr) + i) % N]) begin
               cand_ok = 1'b1;
               cand    = SW'((int'(rr_ptr) + i) % N);
            end
         end
      end
   end

   assign take = load_en && cand_ok && i_valid[cand];

   always_comb begin
      o_ready = '0;
      if (load_en && cand_ok && !i_rst) begin
         o_ready[cand] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_grant <= '0;
         rr_ptr  <= '0;
      end else if (load_en) begin
         if (take) begin
            o_data  <= i_data[int'(cand)*DW +: DW];
            o_valid <= 1'b1;
            o_grant <= cand;
            if (MODE == 1) begin
               rr_ptr <= (int'(cand) == N - 1) ? '0 : cand + 1'b1;
            end
         end else begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_n_1_hs.sv
// Directed bench for mux_n_1_hs: external-select (N=4 and N=3) and round-robin (N=4) instances.
module tb_mux_n_1_hs;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   // Instance a: MODE0, N=4, DW=8
   logic [31:0] data_a;
   logic [3:0]  valid_a;
   logic [3:0]  rdy_a;
   logic [1:0]  sel_a;
   logic [7:0]  odata_a;
   logic        ovalid_a;
   logic        dready_a;
   logic [1:0]  grant_a;
   logic [1:0]  ptr_a;

   // Instance b: MODE1, N=4, DW=8
   logic [31:0] data_b;
   logic [3:0]  valid_b;
   logic [3:0]  rdy_b;
   logic [1:0]  sel_b;
   logic [7:0]  odata_b;
   logic        ovalid_b;
   logic        dready_b;
   logic [1:0]  grant_b;
   logic [1:0]  ptr_b;

   // Instance c: MODE0, N=3, DW=8
   logic [23:0] data_c;
   logic [2:0]  valid_c;
   logic [2:0]  rdy_c;
   logic [1:0]  sel_c;
   logic [7:0]  odata_c;
   logic        ovalid_c;
   logic        dready_c;
   logic [1:0]  grant_c;
   logic [1:0]  ptr_c;

   mux_n_1_hs #(.DW(8), .N(4), .MODE(0)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_data(data_a), .i_valid(valid_a), .o_ready(rdy_a),
      .i_sel(sel_a), .o_data(odata_a), .o_valid(ovalid_a), .i_ready(dready_a),
      .o_grant(grant_a), .o_rr_ptr(ptr_a)
   );

   mux_n_1_hs #(.DW(8), .N(4), .MODE(1)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_data(data_b), .i_valid(valid_b), .o_ready(rdy_b),
      .i_sel(sel_b), .o_data(odata_b), .o_valid(ovalid_b), .i_ready(dready_b),
      .o_grant(grant_b), .o_rr_ptr(ptr_b)
   );

   mux_n_1_hs #(.DW(8), .N(3), .MODE(0)) dut_c (
      .i_clk(clk), .i_rst(rst), .i_data(data_c), .i_valid(valid_c), .o_ready(rdy_c),
      .i_sel(sel_c), .o_data(odata_c), .o_valid(ovalid_c), .i_ready(dready_c),
      .o_grant(grant_c), .o_rr_ptr(ptr_c)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      data_a = '0; valid_a = '0; sel_a = '0; dready_a = 1'b0;
      data_b = '0; valid_b = '0; sel_b = '0; dready_b = 1'b0;
      data_c = '0; valid_c = '0; sel_c = '0; dready_c = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({ovalid_a, ovalid_b, ovalid_c} !== 3'b000) begin
         failures++;
         $display("FAIL reset_valid got=%b exp=000", {ovalid_a, ovalid_b, ovalid_c});
      end
      checks++;
      if ({odata_a, odata_b, odata_c} !== 24'h0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=000000", {odata_a, odata_b, odata_c});
      end
      checks++;
      if ({grant_a, grant_b, grant_c, ptr_b} !== 8'h00) begin
         failures++;
         $display("FAIL reset_grant_ptr got=%h exp=00", {grant_a, grant_b, grant_c, ptr_b});
      end
      checks++;
      if ({rdy_a, rdy_b, rdy_c} !== 11'h0) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=0", {rdy_a, rdy_b, rdy_c});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_select();
      sel_a = 2'd2; valid_a = 4'b0100; data_a[2*8 +: 8] = 8'hA5; dready_a = 1'b1;
      #1;
      checks++;
      if (rdy_a !== 4'b0100) begin
         failures++;
         $display("FAIL sel_ready got=%b exp=0100", rdy_a);
      end
      tick();
      checks++;
      if ({ovalid_a, odata_a, grant_a} !== {1'b1, 8'hA5, 2'd2}) begin
         failures++;
         $display("FAIL sel_out got=v%b d%h g%0d exp=v1 da5 g2", ovalid_a, odata_a, grant_a);
      end
      valid_a = 4'b0000;
      tick();
      checks++;
      if ({ovalid_a, odata_a, grant_a} !== {1'b0, 8'hA5, 2'd2}) begin
         failures++;
         $display("FAIL sel_idle got=v%b d%h g%0d exp=v0 da5 g2", ovalid_a, odata_a, grant_a);
      end
   endtask

   task automatic test_backpressure();
      sel_a = 2'd1; valid_a = 4'b0010; data_a[1*8 +: 8] = 8'h3C; dready_a = 1'b0;
      #1;
      checks++;
      if (rdy_a !== 4'b0010) begin
         failures++;
         $display("FAIL bp_empty_ready got=%b exp=0010", rdy_a);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         sel_a = 2'd3; valid_a = 4'b1000; data_a[3*8 +: 8] = 8'h70 + 8'(i);
         #1;
         checks++;
         if (rdy_a !== 4'b0000) begin
            failures++;
            $display("FAIL bp_stall_ready cyc=%0d got=%b exp=0000", i, rdy_a);
         end
         tick();
         checks++;
         if ({ovalid_a, odata_a, grant_a} !== {1'b1, 8'h3C, 2'd1}) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got=v%b d%h g%0d exp=v1 d3c g1", i, ovalid_a, odata_a, grant_a);
         end
      end
      dready_a = 1'b1;
      #1;
      checks++;
      if (rdy_a !== 4'b1000) begin
         failures++;
         $display("FAIL bp_release_ready got=%b exp=1000", rdy_a);
      end
      tick();
      checks++;
      if ({ovalid_a, odata_a, grant_a} !== {1'b1, 8'h72, 2'd3}) begin
         failures++;
         $display("FAIL bp_release_out got=v%b d%h g%0d exp=v1 d72 g3", ovalid_a, odata_a, grant_a);
      end
      valid_a = 4'b0000;
      tick();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [3:0] exp_r [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      data_b = {8'h13, 8'h12, 8'h11, 8'h10};
      valid_b = 4'b1111; dready_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (rdy_b !== exp_r[i]) begin
            failures++;
            $display("FAIL rr_ready step=%0d got=%b exp=%b", i, rdy_b, exp_r[i]);
         end
         tick();
         checks++;
         if ({ovalid_b, grant_b, odata_b} !== {1'b1, exp_g[i], 8'h10 + 8'(exp_g[i])}) begin
            failures++;
            $display("FAIL rr_out step=%0d got=v%b g%0d d%h exp=v1 g%0d", i, ovalid_b, grant_b, odata_b, exp_g[i]);
         end
      end
   endtask

   task automatic test_wrap();
      // Pointer sits at 1 after five grants; one grant on ch1 moves it to 2.
      valid_b = 4'b0010;
      tick();
      checks++;
      if ({grant_b, ptr_b} !== {2'd1, 2'd2}) begin
         failures++;
         $display("FAIL wrap_setup got=g%0d p%0d exp=g1 p2", grant_b, ptr_b);
      end
      valid_b = 4'b1010;
      #1;
      checks++;
      if (rdy_b !== 4'b1000) begin
         failures++;
         $display("FAIL wrap_ready got=%b exp=1000", rdy_b);
      end
      tick();
      checks++;
      if ({ovalid_b, grant_b, ptr_b} !== {1'b1, 2'd3, 2'd0}) begin
         failures++;
         $display("FAIL wrap_first got=v%b g%0d p%0d exp=v1 g3 p0", ovalid_b, grant_b, ptr_b);
      end
      valid_b = 4'b0010;
      tick();
      checks++;
      if ({ovalid_b, grant_b, odata_b, ptr_b} !== {1'b1, 2'd1, 8'h11, 2'd2}) begin
         failures++;
         $display("FAIL wrap_second got=v%b g%0d d%h p%0d exp=v1 g1 d11 p2", ovalid_b, grant_b, odata_b, ptr_b);
      end
      valid_b = 4'b0000;
      tick();
      checks++;
      if ({ovalid_b, ptr_b} !== {1'b0, 2'd2}) begin
         failures++;
         $display("FAIL wrap_idle got=v%b p%0d exp=v0 p2", ovalid_b, ptr_b);
      end
   endtask

   task automatic test_out_of_range_sel();
      data_c = {8'h33, 8'h22, 8'h11};
      sel_c = 2'd0; valid_c = 3'b111; dready_c = 1'b0;
      tick();
      checks++;
      if ({ovalid_c, odata_c, grant_c} !== {1'b1, 8'h11, 2'd0}) begin
         failures++;
         $display("FAIL oor_load got=v%b d%h g%0d exp=v1 d11 g0", ovalid_c, odata_c, grant_c);
      end
      sel_c = 2'd3;
      dready_c = 1'b1;
      #1;
      checks++;
      if (rdy_c !== 3'b000) begin
         failures++;
         $display("FAIL oor_ready got=%b exp=000", rdy_c);
      end
      tick();
      checks++;
      if ({ovalid_c, odata_c} !== {1'b0, 8'h11}) begin
         failures++;
         $display("FAIL oor_drain got=v%b d%h exp=v0 d11", ovalid_c, odata_c);
      end
   endtask

   task automatic test_mid_reset();
      data_b = {8'h43, 8'h42, 8'h41, 8'h40};
      valid_b = 4'b0100; dready_b = 1'b0;
      tick();
      checks++;
      if ({ovalid_b, grant_b, odata_b} !== {1'b1, 2'd2, 8'h42}) begin
         failures++;
         $display("FAIL mrst_pre got=v%b g%0d d%h exp=v1 g2 d42", ovalid_b, grant_b, odata_b);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({ovalid_b, grant_b, odata_b, ptr_b, rdy_b} !== 17'h0) begin
         failures++;
         $display("FAIL mrst_async got=v%b g%0d d%h p%0d r%b exp=all zero", ovalid_b, grant_b, odata_b, ptr_b, rdy_b);
      end
      tick();
      rst = 1'b0;
      valid_b = 4'b0110; dready_b = 1'b1;
      #1;
      checks++;
      if (rdy_b !== 4'b0010) begin
         failures++;
         $display("FAIL mrst_ready got=%b exp=0010", rdy_b);
      end
      tick();
      checks++;
      if ({ovalid_b, grant_b, odata_b} !== {1'b1, 2'd1, 8'h41}) begin
         failures++;
         $display("FAIL mrst_first got=v%b g%0d d%h exp=v1 g1 d41", ovalid_b, grant_b, odata_b);
      end
   endtask

   initial begin
      test_reset();
      test_select();
      test_backpressure();
      test_round_robin();
      test_wrap();
      test_out_of_range_sel();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
